// File: rtl/sda_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sda_link_pkg
// Purpose  : Shared definitions for the SDA/SCL link arbiter: FSM state
//            encoding, nibble width and a constant-evaluable clog2 helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sda_link_pkg;

    localparam int NIBBLE_W = 4;

    // Arbiter FSM encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    // Bits needed to hold values 0..value-1 (minimum 1 bit for value <= 2)
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sda_link_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Searches ptr+1, ptr+2, ...
//            (mod N) and returns the first requester whose bit is set.
// Ports    : req    - per-requester request vector
//            ptr    - index of the previous winner
//            valid  - at least one request is pending
//            winner - selected requester index (0 when valid is low)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import sda_link_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] winner
);

    always_comb begin
        valid  = |req;
        winner = '0;
        // Walk the ring from the farthest position back to the nearest so the
        // last assignment made is the first requester after ptr.
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                winner = W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sda_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sda_link_arbiter
// Purpose  : Shares one SDA/SCL nibble serializer between N requesters.
//            Round-robin grant, one-cycle start strobe, watchdog on frame
//            completion and an enforced bus-free gap between frames.
// Ports    : sclk, rst (async, active-low)
//            en              - allow new grants
//            req/req_data    - requests and their nibbles (4 bits each)
//            gnt             - one-hot accept pulse
//            ser_data/ser_start/ser_busy/ser_done - serializer interface
//            owner           - last granted requester
//            busy            - FSM not in IDLE
//            frame_done      - normal completion pulse
//            err_timeout/err_clr - sticky watchdog flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module sda_link_arbiter
    import sda_link_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 64,
    parameter int GAP_CYC = 2
) (
    input  logic                   sclk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N-1:0]           req,
    input  logic [NIBBLE_W*N-1:0]  req_data,
    output logic [N-1:0]           gnt,
    output logic [NIBBLE_W-1:0]    ser_data,
    output logic                   ser_start,
    input  logic                   ser_busy,
    input  logic                   ser_done,
    output logic [clog2(N)-1:0]    owner,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_timeout,
    input  logic                   err_clr
);

    localparam int c_OW = clog2(N);
    localparam int c_WW = clog2(TIMEOUT);
    localparam int c_GW = clog2(GAP_CYC + 1);

    localparam logic [c_WW-1:0] c_WDOG_LAST = c_WW'(TIMEOUT - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'(GAP_CYC - 1);
    localparam logic [c_OW-1:0] c_OWNER_RST = c_OW'(N - 1);
    localparam logic [N-1:0]    c_GNT_ONE   = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]          r_state,      w_state_nxt;
    logic [N-1:0]        r_gnt,        w_gnt_nxt;
    logic [NIBBLE_W-1:0] r_ser_data,   w_ser_data_nxt;
    logic                r_ser_start,  w_ser_start_nxt;
    logic [c_OW-1:0]     r_owner,      w_owner_nxt;   // doubles as rr pointer
    logic                r_busy,       w_busy_nxt;
    logic                r_frame_done, w_frame_done_nxt;
    logic                r_err,        w_err_nxt;
    logic [c_WW-1:0]     r_wdog,       w_wdog_nxt;
    logic [c_GW-1:0]     r_gap,        w_gap_nxt;

    logic                w_valid;
    logic [c_OW-1:0]     w_winner;

    rr_pick #(
        .N (N),
        .W (c_OW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_owner),
        .valid  (w_valid),
        .winner (w_winner)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_gnt_nxt        = '0;
        w_ser_data_nxt   = r_ser_data;
        w_ser_start_nxt  = 1'b0;
        w_owner_nxt      = r_owner;
        w_frame_done_nxt = 1'b0;
        // A timeout on the same edge re-sets the flag below, so set wins.
        w_err_nxt        = r_err & ~err_clr;
        w_wdog_nxt       = r_wdog;
        w_gap_nxt        = r_gap;

        case (r_state)
            IDLE: begin
                if (en && w_valid && !ser_busy) begin
                    w_gnt_nxt      = c_GNT_ONE << w_winner;
                    w_ser_data_nxt = req_data[int'(w_winner)*NIBBLE_W +: NIBBLE_W];
                    w_owner_nxt    = w_winner;
                    w_state_nxt    = START;
                end
            end
            START: begin
                w_ser_start_nxt = 1'b1;
                w_wdog_nxt      = '0;
                w_state_nxt     = WAIT;
            end
            WAIT: begin
                w_wdog_nxt = r_wdog + c_WW'(1);
                // Completion is checked first so a done on the last watchdog
                // cycle still counts as a good frame.
                if (ser_done) begin
                    w_frame_done_nxt = 1'b1;
                    w_gap_nxt        = '0;
                    w_state_nxt      = GAP;
                end else if (r_wdog == c_WDOG_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_gap_nxt   = '0;
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt = r_gap + c_GW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_ser_data   <= '0;
            r_ser_start  <= 1'b0;
            r_owner      <= c_OWNER_RST;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_wdog       <= '0;
            r_gap        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_ser_data   <= w_ser_data_nxt;
            r_ser_start  <= w_ser_start_nxt;
            r_owner      <= w_owner_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_err        <= w_err_nxt;
            r_wdog       <= w_wdog_nxt;
            r_gap        <= w_gap_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign ser_data    = r_ser_data;
    assign ser_start   = r_ser_start;
    assign owner       = r_owner;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sda_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sda_link_arbiter
// Purpose  : Self-checking bench for sda_link_arbiter: directed vector table,
//            hand-written corner sequences and a randomized run against an
//            event-time reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sda_link_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 64;
    localparam int GAP_CYC = 2;

    logic           sclk = 1'b0;
    logic           rst = 1'b0;
    logic           en = 1'b0;
    logic [N-1:0]   req = '0;
    logic [4*N-1:0] req_data = '0;
    logic           ser_busy = 1'b0;
    logic           ser_done = 1'b0;
    logic           err_clr = 1'b0;
    logic [N-1:0]   gnt;
    logic [3:0]     ser_data;
    logic           ser_start;
    logic [1:0]     owner;
    logic           busy;
    logic           frame_done;
    logic           err_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 sclk = ~sclk;

    sda_link_arbiter #(
        .N       (N),
        .TIMEOUT (TIMEOUT),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .sclk        (sclk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .ser_data    (ser_data),
        .ser_start   (ser_start),
        .ser_busy    (ser_busy),
        .ser_done    (ser_done),
        .owner       (owner),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    task automatic tick();
        @(posedge sclk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (event times) ----------------
    // A frame granted at edge g strobes at g+1 and watches ser_done from g+2.
    // Ending at edge E frees the bus for a new grant at edge E+GAP_CYC+1.
    int           m_e, m_g, m_free, m_ptr;
    bit           m_in, m_err;
    logic [3:0]   m_data;
    logic [N-1:0] x_gnt;
    bit           x_start, x_fd, x_busy;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 1; i <= N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_e = 0; m_g = -100; m_free = 0; m_ptr = N - 1;
        m_in = 0; m_err = 0; m_data = '0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic [4*N-1:0] d,
                              input logic e_n, input logic sb, input logic sd,
                              input logic clr);
        int w;
        x_gnt = '0; x_start = 0; x_fd = 0;
        if (clr) m_err = 0;
        if (m_in) begin
            if (m_e == m_g + 1) begin
                x_start = 1;
            end else begin
                if (sd) begin
                    x_fd = 1; m_in = 0;
                end else if (m_e - m_g - 2 == TIMEOUT - 1) begin
                    m_err = 1; m_in = 0;
                end
                if (!m_in) m_free = m_e + GAP_CYC + 1;
            end
        end else if (m_e >= m_free && e_n && r != 0 && !sb) begin
            w      = pick(r, m_ptr);
            x_gnt  = N'(1) << w;
            m_data = d[4*w +: 4];
            m_ptr  = w;
            m_g    = m_e;
            m_in   = 1;
        end
        x_busy = m_in || (m_e < m_free - 1);
        m_e++;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        logic        en, sbusy, sdone, clr;
        logic [3:0]  e_gnt;
        logic        e_start, e_fd, e_busy;
        logic [1:0]  e_owner;
        logic [3:0]  e_sdata;
    } vec_t;

    vec_t tbl[10];
    int   order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int n, t_prev;

        //            req     data     en    sb    sd    clr   gnt     st    fd    busy  own   sdata
        tbl[0] = '{4'b0001, 16'h000A, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'hA};
        tbl[1] = '{4'b0000, 16'h000A, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'hA};
        tbl[2] = '{4'b0000, 16'h000A, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'hA};
        tbl[3] = '{4'b0000, 16'h000A, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'hA};
        tbl[4] = '{4'b0000, 16'h000A, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'hA};
        tbl[5] = '{4'b0010, 16'h00B0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'hA};
        tbl[6] = '{4'b0010, 16'h00B0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'hA};
        tbl[7] = '{4'b0010, 16'h00B0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'hA};
        tbl[8] = '{4'b0010, 16'h00B0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 4'hB};
        tbl[9] = '{4'b0000, 16'h00B0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'hB};

        // Reset values
        tick(); tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_sdata", ser_data, 0);
        chk("rst_start", ser_start, 0);
        chk("rst_owner", owner, N - 1);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b1;

        // Single request, ignored ser_done outside WAIT, en/ser_busy gating
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req; req_data = tbl[i].data; en = tbl[i].en;
            ser_busy = tbl[i].sbusy; ser_done = tbl[i].sdone; err_clr = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].e_gnt);
            chk($sformatf("tbl%0d_start", i), ser_start, tbl[i].e_start);
            chk($sformatf("tbl%0d_fd", i), frame_done, tbl[i].e_fd);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_owner", i), owner, tbl[i].e_owner);
            chk($sformatf("tbl%0d_sdata", i), ser_data, tbl[i].e_sdata);
            chk($sformatf("tbl%0d_err", i), err_timeout, 0);
        end
        req = '0; ser_done = 1'b0; ser_busy = 1'b0;

        // Watchdog: now in WAIT, ser_done never comes
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            chk("wd_err_early", err_timeout, 0);
        end
        err_clr = 1'b1;               // clear coinciding with set: set wins
        tick();
        err_clr = 1'b0;
        chk("wd_err_set", err_timeout, 1);
        chk("wd_no_fd", frame_done, 0);
        tick(); chk("wd_gap_busy", busy, 1);
        tick(); chk("wd_idle", busy, 0); chk("wd_err_sticky", err_timeout, 1);
        req = 4'b0100; req_data = 16'h0C00;
        tick();
        chk("wd_next_gnt", gnt, 4'b0100);
        chk("wd_next_owner", owner, 2);
        chk("wd_next_sdata", ser_data, 4'hC);
        req = '0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err", err_timeout, 0);
        chk("clr_start", ser_start, 1);

        // Completion on the last watchdog cycle wins over the timeout
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            chk("edge_fd_early", frame_done, 0);
        end
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        chk("edge_fd", frame_done, 1);
        chk("edge_err", err_timeout, 0);
        tick(); tick();
        chk("edge_idle", busy, 0);

        // Async reset while in WAIT
        req = 4'b0001; req_data = 16'h0005;
        tick();
        chk("ar_gnt", gnt, 4'b0001);
        req = '0;
        tick();
        chk("ar_start", ser_start, 1);
        rst = 1'b0;
        #2;
        chk("ar_busy", busy, 0);
        chk("ar_start_drop", ser_start, 0);
        chk("ar_gnt_drop", gnt, 0);
        chk("ar_owner", owner, 3);
        tick(); tick();
        req = 4'b1001; req_data = 16'h4321; en = 1'b1; rst = 1'b1;
        tick();
        chk("ar_first_gnt", gnt, 4'b0001);
        chk("ar_first_owner", owner, 0);

        // Round-robin fairness with every request held
        req = 4'b1111;
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (gnt == 0 && n < 20) begin
                tick();
                n++;
            end
            chk("rr_wait_bound", int'(n < 20), 1);
            chk($sformatf("rr%0d_gnt", k), gnt, 1 << order[k]);
            chk($sformatf("rr%0d_sdata", k), ser_data, order[k] + 1);
            tick();
            chk($sformatf("rr%0d_start", k), ser_start, 1);
            if (k > 0) chk($sformatf("rr%0d_spacing", k), cyc - t_prev, GAP_CYC + 4);
            t_prev = cyc;
            tick();
            ser_done = 1'b1;
            tick();
            ser_done = 1'b0;
            chk($sformatf("rr%0d_fd", k), frame_done, 1);
        end

        // Randomized run against the reference model
        rst = 1'b0;
        req = '0; en = 1'b0; ser_busy = 1'b0; ser_done = 1'b0; err_clr = 1'b0;
        tick(); tick();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            req      = ($urandom % 4 == 0) ? '0 : N'($urandom);
            req_data = 16'($urandom);
            en       = ($urandom % 8) != 0;
            ser_busy = ($urandom % 4) == 0;
            ser_done = ($urandom % 16) == 0;
            err_clr  = ($urandom % 32) == 0;
            tick();
            model_edge(req, req_data, en, ser_busy, ser_done, err_clr);
            chk("rnd_gnt", gnt, x_gnt);
            chk("rnd_start", ser_start, x_start);
            chk("rnd_fd", frame_done, x_fd);
            chk("rnd_busy", busy, x_busy);
            chk("rnd_err", err_timeout, m_err);
            chk("rnd_owner", owner, m_ptr);
            chk("rnd_sdata", ser_data, m_data);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_time_limit: run did not finish, compared %0d", n_cmp);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
